// File: rtl/spi_serializer.sv
`timescale 1ns/1ps
// spi_serializer: load-triggered SPI mode-0 transmit serializer with a divided SPI clock.
// Define SPI_LSB_FIRST_EN to shift frames LSB first; the default is MSB first.
module spi_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_BITS = 24,
    parameter int CLK_DIV    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] Data_Register,
    input  logic                  ld,
    output logic                  DataBit,
    output logic                  SPI_clk,
    output logic                  CS
);
    localparam int CW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

    state_t                r_state, w_state;
    logic [DW-1:0]         r_div, w_div;
    logic [CW-1:0]         r_cnt, w_cnt, w_idx;
    logic [FRAME_BITS-1:0] r_shreg, w_shreg;
    logic                  r_cs, w_cs, r_sclk, w_sclk, r_bit, w_bit;
    logic                  w_last, w_first, w_unused;

    // r_cnt counts the bits still to be sent after the current one
`ifdef SPI_LSB_FIRST_EN
    assign w_first = Data_Register[0];
    assign w_idx   = CW'(FRAME_BITS) - r_cnt;
`else
    assign w_first = Data_Register[FRAME_BITS-1];
    assign w_idx   = r_cnt - 1'b1;
`endif

    assign w_last   = r_div == DW'(CLK_DIV - 1);
    assign w_unused = ^Data_Register;
    assign DataBit  = r_bit;
    assign SPI_clk  = r_sclk;
    assign CS       = r_cs;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_shreg = r_shreg;
        w_cs    = r_cs;
        w_sclk  = r_sclk;
        w_bit   = r_bit;
        w_div   = (r_state == IDLE || w_last) ? '0 : r_div + 1'b1;
        unique case (r_state)
            IDLE: if (ld) begin
                w_state = LOW;
                w_cnt   = CW'(FRAME_BITS - 1);
                w_shreg = Data_Register[FRAME_BITS-1:0];
                w_cs    = 1'b0;
                w_bit   = w_first;
            end
            LOW: if (w_last) begin
                w_sclk  = 1'b1;
                w_state = HIGH;
            end
            HIGH: if (w_last) begin
                w_sclk = 1'b0;
                if (r_cnt != '0) begin
                    w_bit   = r_shreg[w_idx];
                    w_cnt   = r_cnt - 1'b1;
                    w_state = LOW;
                end else begin
                    w_state = HOLD;
                end
            end
            HOLD: if (w_last) begin
                w_cs    = 1'b1;
                w_bit   = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_bit   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_cnt   <= w_cnt;
            r_shreg <= w_shreg;
            r_cs    <= w_cs;
            r_sclk  <= w_sclk;
            r_bit   <= w_bit;
        end
    end
endmodule

// File: tb/tb_spi_serializer.sv
`timescale 1ns/1ps
// tb_spi_serializer: directed frames checked every cycle against a timing-rule model.
module tb_spi_serializer;
    localparam int F   = 24;
    localparam int CD  = 8;
    localparam int END = CD * (2 * F + 1);

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] Data_Register = 0;
    logic        ld = 0;
    logic        DataBit, SPI_clk, CS;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n0 = 0, n_frames = 0, rises = 0, fall_cyc = 0, rise_cyc = 0;
    bit m_busy = 0, chk_on = 0, prev_sclk = 0, prev_cs = 1;
    logic [F-1:0] m_frame = 0, cap = 0;

    spi_serializer #(.DATA_WIDTH(32), .FRAME_BITS(F), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .Data_Register(Data_Register), .ld(ld),
        .DataBit(DataBit), .SPI_clk(SPI_clk), .CS(CS)
    );

    always #1 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // frame N is the edge that accepted ld; the frame is over END edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_busy <= 0;
        else if (m_busy) begin
            if (cyc + 1 - n0 == END) m_busy <= 0;
        end else if (ld) begin
            m_busy  <= 1;
            n0      <= cyc + 1;
            m_frame <= Data_Register[F-1:0];
        end
    end

    always @(negedge clk) begin
        int t, idx;
        bit e_sclk, e_bit;
        t = cyc - n0;
        idx = (t / (2 * CD) > F - 1) ? F - 1 : t / (2 * CD);
`ifdef SPI_LSB_FIRST_EN
        e_bit = m_busy && m_frame[idx];
`else
        e_bit = m_busy && m_frame[F-1-idx];
`endif
        e_sclk = m_busy && ((t / CD) % 2 == 1) && (t / CD < 2 * F);
        if (chk_on) begin
            chk("cs", {31'b0, CS}, {31'b0, !m_busy});
            chk("sclk", {31'b0, SPI_clk}, {31'b0, e_sclk});
            chk("bit", {31'b0, DataBit}, {31'b0, e_bit});
        end
        if (prev_cs && !CS) begin
            cap <= 0;
            rises <= 0;
            fall_cyc <= cyc;
        end else if (!prev_sclk && SPI_clk) begin
            cap <= {cap[F-2:0], DataBit};
            rises <= rises + 1;
        end
        if (!prev_cs && CS) begin
            rise_cyc <= cyc;
            n_frames <= n_frames + 1;
        end
        prev_sclk <= SPI_clk;
        prev_cs <= CS;
    end

    task automatic pulse(input logic [31:0] d);
        @(posedge clk); #0.2;
        Data_Register = d;
        ld = 1;
        @(posedge clk); #0.2;
        ld = 0;
    endtask

    task automatic wait_frame(input int f0);
        for (int k = 0; k < 1000 && n_frames == f0; k++) @(posedge clk);
        @(negedge clk); #0.2;
        chk("frame_done", {31'b0, n_frames != f0}, 32'd1);
    endtask

    task automatic frame_lits(input string name, input logic [F-1:0] bits);
        chk({name, "_bits"}, {8'b0, cap}, {8'b0, bits});
        chk({name, "_rises"}, rises, F);
        chk({name, "_cs_low"}, rise_cyc - fall_cyc, END);
    endtask

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        #0.2 rst_n = 1;
        chk_on = 1;
        chk("rst_cs", {31'b0, CS}, 32'd1);
        chk("rst_sclk", {31'b0, SPI_clk}, 32'd0);
        chk("rst_bit", {31'b0, DataBit}, 32'd0);
        repeat (50) @(posedge clk);
        #0.2 chk("idle_cs", {31'b0, CS}, 32'd1);

        f0 = n_frames;
        pulse(32'h009E6D55);
        wait_frame(f0);
        frame_lits("t2", 24'b1001_1110_0110_1101_0101_0101);

        repeat (600) @(posedge clk);
        f0 = n_frames;
        pulse(32'h0080F0FE);
        wait_frame(f0);
        frame_lits("t3", 24'b1000_0000_1111_0000_1111_1110);

        f0 = n_frames;
        pulse(32'h00A5C33C);
        repeat (98) @(posedge clk);
        #0.2 Data_Register = 32'h00FFFFFF;
        ld = 1;
        @(posedge clk); #0.2 ld = 0;
        Data_Register = 32'h0;
        wait_frame(f0);
        frame_lits("t4", 24'hA5C33C);
        repeat (20) @(posedge clk);
        #0.2 chk("t4_no_restart", {31'b0, CS}, 32'd1);

        pulse(32'h00123456);
        repeat (149) @(posedge clk);
        #0.5 rst_n = 0;
        #0.1;
        chk("t5_cs", {31'b0, CS}, 32'd1);
        chk("t5_sclk", {31'b0, SPI_clk}, 32'd0);
        chk("t5_bit", {31'b0, DataBit}, 32'd0);
        repeat (3) @(posedge clk);
        #0.2 rst_n = 1;
        repeat (5) @(posedge clk);
        f0 = n_frames;
        pulse(32'h00C0FFEE);
        wait_frame(f0);
        frame_lits("t5", 24'hC0FFEE);

        f0 = n_frames;
        pulse(32'h00000001);
        wait_frame(f0);
`ifdef SPI_LSB_FIRST_EN
        frame_lits("t6", 24'h800000);
`else
        frame_lits("t6", 24'h000001);
`endif
        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
